alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage of the multicycle datapath. Accepts a decoded op and operands with a valid/ready
//  handshake and latches them. Drives the combinational ALU and holds MUL/DIV/MOD for a fixed cycle
//  count. Registers the result (ALUOut) and presents it to writeback with a valid/ready handshake.
// PARAMETERS
//  WORD_SIZE   64  operand/result width
//  TAG_W       5   destination-register tag width
//  MUL_CYCLES  4   cycles in BUSY for ALU_MUL (>=1)
//  DIV_CYCLES  16  cycles in BUSY for ALU_DIV/ALU_MOD (>=1)
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-high
//  flush       in   1          cancel held or in-flight op (pipeline redirect)
//  in_valid    in   1          op/operands valid
//  in_ready    out  1          stage can accept this cycle
//  in_op       in   4          OP.ALU_* code
//  in_a,in_b   in   WORD_SIZE  operands (unsigned)
//  in_tag      in   TAG_W      destination tag, passed through
//  out_valid   out  1          result valid
//  out_ready   in   1          writeback accepts
//  out_result  out  WORD_SIZE  registered ALU result
//  out_tag     out  TAG_W      tag of out_result
//  out_zero    out  1          out_result == 0
//  out_divz    out  1          DIV/MOD issued with B == 0
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. Reset -> state IDLE; out_valid, out_divz,
//    out_zero, busy = 0; out_result, out_tag = 0. Reset overrides flush and all handshakes.
//  - FSM: IDLE -> (accept, 1-cycle op) DONE; IDLE -> (accept, MUL/DIV/MOD) BUSY with cnt=N-1;
//    BUSY -> cnt==0: DONE, else cnt--; DONE -> out_ready: IDLE, or DONE again if a new op is accepted.
//  - Accept = in_valid & in_ready. in_ready = !flush & (IDLE | (DONE & out_ready)). Back-to-back is
//    allowed: the result leaves and the next op enters on the same edge.
//  - Latency from accept edge to out_valid: 1 cycle for single-cycle ops, 1+MUL_CYCLES for MUL,
//    1+DIV_CYCLES for DIV/MOD. Operands stay latched until DONE; in_* are ignored while BUSY.
//  - out_result/out_tag/out_zero/out_divz are stable while out_valid & !out_ready.
//  - Arithmetic: all unsigned, modulo 2^WORD_SIZE. ADD/SUB/MUL keep the low WORD_SIZE bits.
//    SL: A<<B; B>=WORD_SIZE gives 0. NOT uses A only. EQ/NEQ/LT/LE/GT/GE give 0 or 1, zero-extended.
//    NEQ is A!=B.
//  - Divide by zero: DIV gives all-ones and MOD gives A, with out_divz=1. Latency is unchanged.
//  - flush: the next edge moves to IDLE and drops out_valid. A held result is lost even if out_ready=1.
//    No accept happens in a flush cycle.
//  - cnt width = clog2(max(MUL_CYCLES,DIV_CYCLES)). The counter never wraps; it is loaded only on accept.
// STRUCTURE
//  - Shared package (opcodes.v / OP): the ALU_* 4-bit codes ADD=0 SUB=1 MUL=2 SL=3 DIV=4 MOD=5
//    NOT=6 OR=7 AND=8 XOR=9 EQ=10 NEQ=11 LT=12 LE=13 GT=14 GE=15, plus the exec-stage state
//    encoding (IDLE=0, BUSY=1, DONE=2).
//  - Sub-module: one instance of ALU (WORD_SIZE passed through), fed from the operand latches.
//    This stage owns the divide-by-zero override, multi-cycle classification, FSM, counter and
//    output registers.
// TESTING
//  1. ADD a=5 b=7 tag=3, out_ready=1 -> out_valid 1 cycle after accept, result=12, tag=3,
//     zero=0; busy drops the next cycle.
//  2. DIV a=100 b=7 (DIV_CYCLES=16) -> in_ready=0 for 16 cycles, out_valid at accept+17,
//     result=14; MOD same operands -> 2.
//  3. DIV a=9 b=0 -> result=64'hFFFF_FFFF_FFFF_FFFF, divz=1; MOD a=9 b=0 -> result=9, divz=1.
//  4. Backpressure: SUB 3-5 with out_ready=0 for 5 cycles -> result=2^64-2 held stable, in_ready=0.
//     Raise out_ready with in_valid (XOR) -> both transfers occur on the same edge.
//  5. flush mid-MUL (cycle 2 of 4) -> next cycle IDLE, out_valid never asserts. A following
//     EQ 8,8 -> result=1.
//  6. reset asserted in BUSY and in DONE -> next edge: out_valid=0, busy=0, out_result=0.
//     Corners: SL 1<<64 -> 0; NEQ 4,4 -> 0, zero=1.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM state encoding
// and small opcode classification helpers.
package alu_exec_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_SL  = 4'd3,
        ALU_DIV = 4'd4,
        ALU_MOD = 4'd5,
        ALU_NOT = 4'd6,
        ALU_OR  = 4'd7,
        ALU_AND = 4'd8,
        ALU_XOR = 4'd9,
        ALU_EQ  = 4'd10,
        ALU_NEQ = 4'd11,
        ALU_LT  = 4'd12,
        ALU_LE  = 4'd13,
        ALU_GT  = 4'd14,
        ALU_GE  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } exec_state_e;

    // Ops that hold the stage in BUSY before their result is registered.
    function automatic logic is_multicycle(alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

    // Ops subject to the divide-by-zero override.
    function automatic logic is_divide(alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Purely combinational ALU. All arithmetic is unsigned and truncated to
// WORD_SIZE bits. A zero divisor yields 0 here; the execute stage applies
// the architectural divide-by-zero result on top of this.
module alu_exec_stage_alu
    import alu_exec_stage_pkg::*;
#(
    parameter int WORD_SIZE = 64
) (
    input  alu_op_e              op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] y
);

    localparam logic [WORD_SIZE-1:0] WS = WORD_SIZE'(WORD_SIZE);
    localparam int PAD = WORD_SIZE - 1;

    logic b_zero;
    assign b_zero = (b == '0);

    // Select the operation result; comparisons are zero-extended flags.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_MUL: y = a * b;
            ALU_SL:  y = (b >= WS) ? '0 : (a << b);
            ALU_DIV: y = b_zero ? '0 : (a / b);
            ALU_MOD: y = b_zero ? '0 : (a % b);
            ALU_NOT: y = ~a;
            ALU_OR:  y = a | b;
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            ALU_EQ:  y = {{PAD{1'b0}}, (a == b)};
            ALU_NEQ: y = {{PAD{1'b0}}, (a != b)};
            ALU_LT:  y = {{PAD{1'b0}}, (a <  b)};
            ALU_LE:  y = {{PAD{1'b0}}, (a <= b)};
            ALU_GT:  y = {{PAD{1'b0}}, (a >  b)};
            ALU_GE:  y = {{PAD{1'b0}}, (a >= b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage of the multicycle datapath. Latches one op on a valid/ready
// handshake, runs it through the ALU (holding MUL/DIV/MOD in BUSY for a
// fixed count), registers the result and offers it to writeback.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | empty, ready for a new op
// BUSY  | multicycle op in flight, counter running down to 0
// DONE  | registered result valid, waiting for out_ready
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WORD_SIZE  = 64,
    parameter int TAG_W      = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [WORD_SIZE-1:0] in_a,
    input  logic [WORD_SIZE-1:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_zero,
    output logic                 out_divz,
    output logic                 busy
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    exec_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    alu_op_e              op_q, op_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [WORD_SIZE-1:0] res_q, res_d;
    logic [TAG_W-1:0]     res_tag_q, res_tag_d;
    logic                 zero_q, zero_d;
    logic                 divz_q, divz_d;

    alu_op_e              in_op_e;
    logic                 accept;
    alu_op_e              sel_op;
    logic [WORD_SIZE-1:0] sel_a, sel_b;
    logic [TAG_W-1:0]     sel_tag;
    logic [WORD_SIZE-1:0] alu_y;
    logic [WORD_SIZE-1:0] final_res;
    logic                 div_by_zero;
    logic                 load_result;

    assign in_op_e = alu_op_e'(in_op);
    assign accept  = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to IDLE (no accept can occur then).
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = is_multicycle(in_op_e) ? ST_BUSY : ST_DONE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        state_d = is_multicycle(in_op_e) ? ST_BUSY : ST_DONE;
                    end else if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // A single-cycle op registers its result on the same edge that accepts it,
    // so on accept the ALU sees the incoming operands instead of the latches.
    always_comb begin
        sel_op  = accept ? in_op_e : op_q;
        sel_a   = accept ? in_a    : a_q;
        sel_b   = accept ? in_b    : b_q;
        sel_tag = accept ? in_tag  : tag_q;
    end

    alu_exec_stage_alu #(
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (alu_y)
    );

    // Divide-by-zero override: DIV returns all-ones, MOD returns the dividend.
    always_comb begin
        div_by_zero = is_divide(sel_op) && (sel_b == '0);
        final_res   = alu_y;
        if (div_by_zero) begin
            final_res = (sel_op == ALU_DIV) ? '1 : sel_a;
        end
    end

    // Operand latches, cycle counter and output register next values.
    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_tag_d = res_tag_q;
        zero_d    = zero_q;
        divz_d    = divz_q;

        if (accept) begin
            op_d  = in_op_e;
            a_d   = in_a;
            b_d   = in_b;
            tag_d = in_tag;
            if (is_multicycle(in_op_e)) begin
                cnt_d = (in_op_e == ALU_MUL) ? MUL_LOAD : DIV_LOAD;
            end
        end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        load_result = !flush &&
                      ((accept && !is_multicycle(in_op_e)) ||
                       ((state_q == ST_BUSY) && (cnt_q == '0)));

        if (load_result) begin
            res_d     = final_res;
            res_tag_d = sel_tag;
            zero_d    = (final_res == '0);
            divz_d    = div_by_zero;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_tag_q <= '0;
            zero_q    <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            res_tag_q <= res_tag_d;
            zero_q    <= zero_d;
            divz_q    <= divz_d;
        end
    end

    assign out_result = res_q;
    assign out_tag    = res_tag_q;
    assign out_zero   = zero_q;
    assign out_divz   = divz_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed scenarios followed by randomized ops,
// each checked against an arithmetic reference model.
module tb_alu_exec_stage;

    localparam int WS   = 64;
    localparam int TW   = 5;
    localparam int MULC = 4;
    localparam int DIVC = 16;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic          out_zero, out_divz, busy;
    logic [3:0]    in_op;
    logic [WS-1:0] in_a, in_b, out_result;
    logic [TW-1:0] in_tag, out_tag;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(
        .WORD_SIZE  (WS),
        .TAG_W      (TW),
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_divz   (out_divz),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic, written directly from the operation definitions.
    task automatic ref_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] r, output logic dz);
        dz = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a * b;
            4'd3:  r = (b >= 64) ? 64'd0 : (a << b);
            4'd4:  if (b == 0) begin r = {64{1'b1}}; dz = 1'b1; end else r = a / b;
            4'd5:  if (b == 0) begin r = a;          dz = 1'b1; end else r = a % b;
            4'd6:  r = ~a;
            4'd7:  r = a | b;
            4'd8:  r = a & b;
            4'd9:  r = a ^ b;
            4'd10: r = {63'd0, a == b};
            4'd11: r = {63'd0, a != b};
            4'd12: r = {63'd0, a <  b};
            4'd13: r = {63'd0, a <= b};
            4'd14: r = {63'd0, a >  b};
            default: r = {63'd0, a >= b};
        endcase
    endtask

    function automatic int ref_latency(input logic [3:0] op);
        if (op == 4'd2) return 1 + MULC;
        if (op == 4'd4 || op == 4'd5) return 1 + DIVC;
        return 1;
    endfunction

    // Present an op and hold it until the accepting edge has passed.
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TW-1:0] tag);
        int guard;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 50) begin step(); guard++; end
        check("send_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Full transaction: accept, latency, result fields, optional backpressure, drain.
    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [TW-1:0] tag, input int hold);
        int lat, ready_hi;
        logic [63:0] r;
        logic dz;
        out_ready = (hold == 0);
        send(op, a, b, tag);
        lat = 1; ready_hi = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_hi++;
            step();
            lat++;
        end
        ref_op(op, a, b, r, dz);
        check({name, "_lat"},   64'(lat), 64'(ref_latency(op)));
        check({name, "_inrdy"}, 64'(ready_hi), 64'd0);
        check({name, "_res"},   out_result, r);
        check({name, "_tag"},   64'(out_tag), 64'(tag));
        check({name, "_zero"},  {63'd0, out_zero}, {63'd0, r == 0});
        check({name, "_divz"},  {63'd0, out_divz}, {63'd0, dz});
        for (int i = 0; i < hold; i++) begin
            step();
            check({name, "_hold_v"},   {63'd0, out_valid}, 64'd1);
            check({name, "_hold_res"}, out_result, r);
            check({name, "_hold_rdy"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        check({name, "_drain_v"}, {63'd0, out_valid}, 64'd0);
        check({name, "_drain_b"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat, seen;
        logic [3:0]  rop;
        logic [63:0] ra, rb;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        step(); step();
        check("rst_valid",  {63'd0, out_valid}, 64'd0);
        check("rst_busy",   {63'd0, busy}, 64'd0);
        check("rst_result", out_result, 64'd0);
        check("rst_tag",    64'(out_tag), 64'd0);
        check("rst_divz",   {63'd0, out_divz}, 64'd0);
        reset = 1'b0;
        #1;
        check("idle_ready", {63'd0, in_ready}, 64'd1);

        run_op("add", 4'd0, 64'd5, 64'd7, 5'd3, 0);
        run_op("div", 4'd4, 64'd100, 64'd7, 5'd4, 0);
        run_op("mod", 4'd5, 64'd100, 64'd7, 5'd5, 0);
        run_op("divz", 4'd4, 64'd9, 64'd0, 5'd6, 0);
        run_op("modz", 4'd5, 64'd9, 64'd0, 5'd7, 1);
        run_op("mul", 4'd2, 64'hFFFF_FFFF_0000_0003, 64'd5, 5'd8, 0);

        // Backpressure then back-to-back handoff.
        out_ready = 1'b0;
        send(4'd1, 64'd3, 64'd5, 5'd9);
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_res",   out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_stable", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
            check("bp_rdy",    {63'd0, in_ready}, 64'd0);
        end
        in_op = 4'd9; in_a = 64'hF0F0; in_b = 64'h0FF0; in_tag = 5'd10;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_rdy", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        check("b2b_valid", {63'd0, out_valid}, 64'd1);
        check("b2b_res",   out_result, 64'hFF00);
        check("b2b_tag",   64'(out_tag), 64'd10);
        step();
        check("b2b_drain", {63'd0, out_valid}, 64'd0);

        // Flush mid-MUL, with a competing op presented during the flush cycle.
        send(4'd2, 64'd3, 64'd4, 5'd11);
        step();
        flush = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_a = 64'd1; in_b = 64'd1;
        #1;
        check("flush_rdy", {63'd0, in_ready}, 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("flush_novalid", 64'(seen), 64'd0);
        run_op("eq", 4'd10, 64'd8, 64'd8, 5'd12, 0);

        // Reset in BUSY.
        send(4'd4, 64'd50, 64'd3, 5'd13);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstb_valid", {63'd0, out_valid}, 64'd0);
        check("rstb_busy",  {63'd0, busy}, 64'd0);
        check("rstb_res",   out_result, 64'd0);

        // Reset in DONE.
        out_ready = 1'b0;
        send(4'd0, 64'd5, 64'd7, 5'd14);
        check("rstd_pre", out_result, 64'd12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstd_valid", {63'd0, out_valid}, 64'd0);
        check("rstd_busy",  {63'd0, busy}, 64'd0);
        check("rstd_res",   out_result, 64'd0);
        check("rstd_tag",   64'(out_tag), 64'd0);

        run_op("sl64", 4'd3, 64'd1, 64'd64, 5'd15, 0);
        run_op("sl63", 4'd3, 64'd1, 64'd63, 5'd16, 0);
        run_op("neq",  4'd11, 64'd4, 64'd4, 5'd17, 0);
        run_op("not",  4'd6, 64'h1234, 64'hDEAD, 5'd18, 0);

        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'd0;
                1:       rb = 64'($urandom_range(0, 70));
                2:       rb = ra;
                default: rb = {$urandom, $urandom};
            endcase
            run_op("rnd", rop, ra, rb, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
